// File: rtl/apb_regfile.sv
// APB slave register file with byte strobes, programmable wait states and out-of-range PSLVERR.
// Latency: setup + WAIT_STATES + 1 access cycle; prdata/pready/pslverr are registered.
// Backpressure: pready stays low for WAIT_STATES access cycles; dropping psel mid-transfer aborts it.
module apb_regfile #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [NB-1:0]     pstrb_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup;
    logic [ADDR_W-1:0] addr_cur;
    logic              in_range;
    logic              commit;

    assign setup = psel && !penable;
    // With no wait states DONE is entered on the setup edge itself, before addr_q is loaded.
    assign addr_cur = (state == IDLE) ? paddr : addr_q;
    assign in_range = ({1'b0, addr_cur} < DEPTH_L);
    assign commit   = (state == DONE) && psel && penable && pwrite_q && in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
        end else begin
            if (state == IDLE && setup) begin
                addr_q   <= paddr;
                pwrite_q <= pwrite;
                pwdata_q <= pwdata;
                pstrb_q  <= pstrb;
            end
            pready  <= (state_nxt == DONE);
            pslverr <= (state_nxt == DONE) && !in_range;
            if (state_nxt == DONE && state != DONE && !pwrite_q && state == WAIT) begin
                prdata <= in_range ? mem[addr_cur[IDX_W-1:0]] : '0;
            end else if (state_nxt == DONE && state == IDLE && !pwrite) begin
                prdata <= in_range ? mem[addr_cur[IDX_W-1:0]] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (pstrb_q[i]) mem[addr_q[IDX_W-1:0]][8*i +: 8] <= pwdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/apb_regfile.md
# apb_regfile

Parametrised APB slave register file: the next generation of the team's 8x8 APB memory slave. It adds configurable data width and depth, byte-lane write strobes, programmable wait states via PREADY, and PSLVERR on out-of-range addresses. It sits on the APB peripheral bus behind the bridge as generic scratch/config storage for the rest of the design.

## Interface
- DATA_W, 32, data bus width in bits; multiple of 8, range 8..64
- ADDR_W, 8, PADDR width; PADDR is a word index, not a byte address
- DEPTH, 16, number of words; must be at most 2^ADDR_W
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion; range 0..15

- clk  input  1  clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- paddr  input  ADDR_W  word address
- psel  input  1  slave select
- penable  input  1  access-phase indicator
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  DATA_W  write data
- pstrb  input  DATA_W/8  byte-lane write enables; lane i is pwdata[8i+7:8i]
- prdata  output  DATA_W  read data, registered
- pready  output  1  transfer-complete indication, registered
- pslverr  output  1  error response, valid only while pready=1

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - A rising edge sampling psel=1, penable=0 (setup) latches paddr, pwrite, pwdata, pstrb.
  - If WAIT_STATES=0, go to DONE. Otherwise go to WAIT with the counter loaded to WAIT_STATES.
- WAIT: the counter decrements each edge. When it reaches 0, go to DONE.
- DONE: pready=1 for exactly one cycle, then return to IDLE.
- Address range: an address >= DEPTH is out of range.
  - Reads: prdata=0 and pslverr=1 during DONE.
  - Writes: pslverr=1 during DONE and no storage is modified.
- Read, in range: prdata is loaded with mem[addr] on the edge entering DONE. prdata holds that value until the next read completes.
- Write, in range: on the edge leaving DONE, for every lane i with pstrb[i]=1, mem[addr] lane i <= pwdata lane i. Lanes with pstrb[i]=0 are unchanged. A write with pstrb all zero modifies nothing and is not an error.
- Abort: if psel=0 is sampled in WAIT or DONE:
  - go to IDLE immediately;
  - no write is committed;
  - pready and pslverr are 0 next cycle;
  - prdata keeps its prior value.
- Setup-phase violation: psel=1 with penable=1 sampled in IDLE is ignored; the state stays IDLE.
- Back-to-back: a new setup is accepted in the cycle after DONE (IDLE). There is no pipelining across transfers.
- Reset (reset=0, asynchronous, any state including mid-transfer):
  - state=IDLE, counter=0;
  - prdata=0, pready=0, pslverr=0;
  - all DEPTH words cleared to 0;
  - an in-flight write is discarded.
- pwdata, pstrb, paddr and pwrite are sampled only at setup. Changes during the access phase have no effect.

## Timing
- Reset values: prdata=0, pready=0, pslverr=0, all memory words 0.
- Transfer length from setup cycle to completion edge, inclusive: 2 + WAIT_STATES cycles.
  - Setup cycle (psel=1, penable=0).
  - WAIT_STATES access cycles with pready=0.
  - One access cycle with pready=1.
- Completion: the bus transfer completes on the edge sampling psel & penable & pready. The write commits on that same edge.
- Read-after-write: a read of the same address issued in the cycle after a write completes returns the new data.
- pready and pslverr are never high outside DONE. pslverr=1 implies pready=1.
- Deasserting reset is synchronised internally by the caller's reset tree. The block accepts a setup on the first edge with reset=1.

## Test plan
- Reset state: hold reset=0, then release. Read all DEPTH addresses with WAIT_STATES=0 -> every prdata=0, pslverr=0, each transfer exactly 2 cycles.
- Full-width write and read: DATA_W=32. Write 0xDEADBEEF to addr 3 with pstrb=4'b1111, then read addr 3 -> prdata=0xDEADBEEF, pready high on the 2nd cycle of each transfer.
- Byte strobes: addr 5 holds 0x11223344. Write 0xAABBCCDD with pstrb=4'b0101, then read addr 5 -> 0x11BB33DD.
- Wait states: WAIT_STATES=3. Write then read addr 0 -> pready low for 3 access cycles then high for 1. Each transfer is 5 cycles and the data round-trips.
- Error response: DEPTH=16. Write 0x12345678 to addr 16, then read addr 16 -> pslverr=1 with pready on both, read prdata=0. A following read of addr 0 returns its unchanged value.
- Abort and reset mid-op:
  - WAIT_STATES=2. Drop psel in the first wait cycle of a write to addr 2 -> addr 2 unchanged, state back to IDLE.
  - Assert reset during a wait cycle of a write -> outputs 0 immediately and memory is all 0 afterwards.
